// File: rtl/board_draw_sched.sv
// board_draw_sched: walks the 8x8 Othello board through the 12x12 tile plotter,
// one start/done job per cell. Define CURSOR_OVERLAY_EN to frame the cursor cell.
module board_draw_sched #(
  parameter int TILE_SIZE = 12,
  parameter int X_ORIGIN  = 16,
  parameter int Y_ORIGIN  = 12,
  parameter int BOARD_DIM = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       full_req,
  input  logic       cell_req,
  input  logic [2:0] cell_row,
  input  logic [2:0] cell_col,
  input  logic [2:0] cursor_row,
  input  logic [2:0] cursor_col,
  output logic [5:0] board_addr,
  input  logic [1:0] board_data,
  output logic [7:0] tile_x,
  output logic [6:0] tile_y,
  output logic [1:0] tile_select,
  output logic       tile_start,
  input  logic       tile_done,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] dbg_state
);

  // Plotter handshake: tile_start is a one-cycle launch; tile_x/y/select hold
  // from that cycle until the plotter answers with a one-cycle tile_done.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_READ  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_NEXT  = 3'd5
`ifdef CURSOR_OVERLAY_EN
    , S_OVL_START = 3'd6
    , S_OVL_WAIT  = 3'd7
`endif
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [5:0] r_index;
  logic       r_full_mode;
  logic       r_full_pend;
  logic       r_cell_pend;
  logic [2:0] r_pend_row;
  logic [2:0] r_pend_col;
  logic [1:0] r_select;

  logic       w_take_full;
  logic       w_take_cell;
  logic       w_last;
  logic [1:0] w_map_sel;
  logic [7:0] w_tile_x;
  logic [6:0] w_tile_y;

  assign w_take_full = full_req | r_full_pend;
  assign w_take_cell = cell_req | r_cell_pend;
  assign w_last      = (r_index == 6'(BOARD_DIM * BOARD_DIM - 1));
  assign w_tile_x    = 8'(X_ORIGIN) + 8'(r_index[2:0]) * 8'(TILE_SIZE);
  assign w_tile_y    = 7'(Y_ORIGIN) + 7'(r_index[5:3]) * 7'(TILE_SIZE);
  assign dbg_state   = r_state;

`ifdef CURSOR_OVERLAY_EN
  logic w_at_cursor;
  assign w_at_cursor = (r_index == {cursor_row, cursor_col});
`else
  logic w_unused_cursor;
  assign w_unused_cursor = ^{cursor_row, cursor_col};
`endif

  // Code 10 is not a legal cell state; draw it as empty.
  always_comb begin
    case (board_data)
      2'b01:   w_map_sel = 2'd1;
      2'b11:   w_map_sel = 2'd3;
      default: w_map_sel = 2'd0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_take_full || w_take_cell) w_next_state = S_FETCH;
      S_FETCH: w_next_state = S_READ;
      S_READ:  w_next_state = S_START;
      S_START: w_next_state = S_WAIT;
`ifdef CURSOR_OVERLAY_EN
      S_WAIT:      if (tile_done) w_next_state = w_at_cursor ? S_OVL_START : S_NEXT;
      S_OVL_START: w_next_state = S_OVL_WAIT;
      S_OVL_WAIT:  if (tile_done) w_next_state = S_NEXT;
`else
      S_WAIT:  if (tile_done) w_next_state = S_NEXT;
`endif
      S_NEXT:  w_next_state = (r_full_mode && !w_last) ? S_FETCH : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // A full redraw repaints every cell, so it also swallows any pending cell job.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_index     <= '0;
      r_full_mode <= 1'b0;
      r_full_pend <= 1'b0;
      r_cell_pend <= 1'b0;
      r_pend_row  <= '0;
      r_pend_col  <= '0;
      r_select    <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_take_full) begin
          r_index     <= '0;
          r_full_mode <= 1'b1;
          r_full_pend <= 1'b0;
          r_cell_pend <= 1'b0;
        end else if (w_take_cell) begin
          r_index     <= cell_req ? {cell_row, cell_col} : {r_pend_row, r_pend_col};
          r_full_mode <= 1'b0;
          r_cell_pend <= 1'b0;
        end
      end else begin
        if (full_req) r_full_pend <= 1'b1;
        if (cell_req) begin
          r_cell_pend <= 1'b1;
          r_pend_row  <= cell_row;
          r_pend_col  <= cell_col;
        end
      end
      if (r_state == S_READ) r_select <= w_map_sel;
      if (r_state == S_NEXT && r_full_mode && !w_last) r_index <= r_index + 6'd1;
    end
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    board_addr  = r_index;
    tile_start  = 1'b0;
    tile_x      = '0;
    tile_y      = '0;
    tile_select = '0;
    frame_done  = 1'b0;
    case (r_state)
      S_START: begin
        tile_start  = 1'b1;
        tile_x      = w_tile_x;
        tile_y      = w_tile_y;
        tile_select = r_select;
      end
      S_WAIT: begin
        tile_x      = w_tile_x;
        tile_y      = w_tile_y;
        tile_select = r_select;
      end
`ifdef CURSOR_OVERLAY_EN
      S_OVL_START: begin
        tile_start  = 1'b1;
        tile_x      = w_tile_x;
        tile_y      = w_tile_y;
        tile_select = 2'd2;
      end
      S_OVL_WAIT: begin
        tile_x      = w_tile_x;
        tile_y      = w_tile_y;
        tile_select = 2'd2;
      end
`endif
      S_NEXT:  frame_done = r_full_mode && w_last;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_board_draw_sched.sv
// tb_board_draw_sched: job-level reference model of the board draw sequencer,
// a reactive plotter/RAM model, directed scenarios and a random request phase.
`timescale 1ns/1ps
module tb_board_draw_sched;

`ifdef CURSOR_OVERLAY_EN
  localparam int OVL = 1;
`else
  localparam int OVL = 0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       full_req = 1'b0;
  logic       cell_req = 1'b0;
  logic [2:0] cell_row = '0;
  logic [2:0] cell_col = '0;
  logic [2:0] cursor_row = '0;
  logic [2:0] cursor_col = '0;
  logic [5:0] board_addr;
  logic [1:0] board_data = '0;
  logic [7:0] tile_x;
  logic [6:0] tile_y;
  logic [1:0] tile_select;
  logic       tile_start;
  logic       tile_done;
  logic       busy;
  logic       frame_done;
  logic [2:0] dbg_state;
  logic       plot_done = 1'b0;
  logic       spur_done = 1'b0;

  assign tile_done = plot_done | spur_done;

  // ---------------- clock / reset
  always #5 clock = ~clock;

  board_draw_sched dut (
    .clock(clock), .resetn(resetn), .full_req(full_req), .cell_req(cell_req),
    .cell_row(cell_row), .cell_col(cell_col), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .board_addr(board_addr), .board_data(board_data), .tile_x(tile_x), .tile_y(tile_y),
    .tile_select(tile_select), .tile_start(tile_start), .tile_done(tile_done),
    .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  int vec = 0;
  int bad = 0;
  int n_frames = 0;
  logic [16:0] start_log[$];

  // ---------------- board RAM, one-cycle read latency
  logic [1:0] mem [64];
  always @(posedge clock) board_data <= mem[board_addr];

  // ---------------- reference model: jobs expand into expected tile lists
  logic [16:0] exp_q[$];
  int   m_left = 0;
  bit   m_active = 0, m_drain = 0, m_drain_full = 0, m_full = 0, m_fp = 0, m_cp = 0;
  logic [2:0] m_pr = '0, m_pc = '0;

  function automatic logic [1:0] sel_of(logic [1:0] d);
    if (d == 2'b01) return 2'd1;
    if (d == 2'b11) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [16:0] tile_of(int row, int col, logic [1:0] sel);
    int x = 16 + col * 12;
    int y = 12 + row * 12;
    return {8'(x), 7'(y), sel};
  endfunction

  task automatic queue_cell(int row, int col);
    exp_q.push_back(tile_of(row, col, sel_of(mem[row * 8 + col])));
    m_left++;
`ifdef CURSOR_OVERLAY_EN
    if (row == int'(cursor_row) && col == int'(cursor_col)) begin
      exp_q.push_back(tile_of(row, col, 2'd2));
      m_left++;
    end
`endif
  endtask

  // A job stays busy until its last tile_done, plus one wrap-up cycle; requests
  // seen meanwhile become pending, and a starting full job drops a pending cell.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_active = 0; m_drain = 0; m_drain_full = 0; m_full = 0;
      m_fp = 0; m_cp = 0; m_left = 0;
      exp_q.delete();
    end else if (m_active || m_drain) begin
      if (m_drain) m_drain = 0;
      else if (tile_done) begin
        m_left--;
        if (m_left == 0) begin
          m_active = 0; m_drain = 1; m_drain_full = m_full;
        end
      end
      if (full_req) m_fp = 1;
      if (cell_req) begin m_cp = 1; m_pr = cell_row; m_pc = cell_col; end
    end else if (full_req || m_fp) begin
      m_fp = 0; m_cp = 0; m_full = 1; m_active = 1; m_left = 0;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) queue_cell(r, c);
    end else if (cell_req || m_cp) begin
      m_cp = 0; m_full = 0; m_active = 1; m_left = 0;
      if (cell_req) queue_cell(int'(cell_row), int'(cell_col));
      else          queue_cell(int'(m_pr), int'(m_pc));
    end
  end

  // ---------------- scoreboard / compare process
  logic [16:0] cur_exp = '0;
  logic [16:0] got_tile;
  always @(negedge clock) begin
    if (resetn) begin
      vec++;
      if (busy !== (m_active || m_drain)) begin
        bad++;
        $display("FAIL busy: got %b want %b at %0t", busy, (m_active || m_drain), $time);
      end
      vec++;
      if (frame_done !== (m_drain && m_drain_full)) begin
        bad++;
        $display("FAIL frame_done: got %b want %b at %0t", frame_done, (m_drain && m_drain_full), $time);
      end
      if (frame_done === 1'b1) n_frames++;
      if (tile_start === 1'b1) begin
        got_tile = {tile_x, tile_y, tile_select};
        start_log.push_back(got_tile);
        vec++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL tile_start: got unexpected tile x=%0d y=%0d sel=%0d, want none at %0t",
                   tile_x, tile_y, tile_select, $time);
        end else begin
          cur_exp = exp_q.pop_front();
          if (got_tile !== cur_exp) begin
            bad++;
            $display("FAIL tile: got x=%0d y=%0d sel=%0d want x=%0d y=%0d sel=%0d at %0t",
                     tile_x, tile_y, tile_select, cur_exp[16:9], cur_exp[8:2], cur_exp[1:0], $time);
          end
        end
      end
    end
  end

  // ---------------- plotter model: answers each start after a latency
  int p_cnt = 0;
  int plot_lat = 1;
  bit rand_lat = 0;
  always @(negedge clock) begin
    if (!resetn) begin
      p_cnt = 0;
      plot_done = 1'b0;
    end else begin
      plot_done = 1'b0;
      if (p_cnt > 0) begin
        p_cnt--;
        if (p_cnt == 0) begin
          plot_done = 1'b1;
          vec++;
          if ({tile_x, tile_y, tile_select} !== cur_exp) begin
            bad++;
            $display("FAIL tile_hold: got x=%0d y=%0d sel=%0d want x=%0d y=%0d sel=%0d at %0t",
                     tile_x, tile_y, tile_select, cur_exp[16:9], cur_exp[8:2], cur_exp[1:0], $time);
          end
        end
      end
      if (tile_start === 1'b1) p_cnt = rand_lat ? int'($urandom_range(1, 4)) : plot_lat;
    end
  end

  // ---------------- driver / check tasks
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    vec++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((m_active || m_drain || m_fp || m_cp || busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    vec++;
    if (n >= budget) begin
      bad++;
      $display("FAIL wait_idle: got still busy after %0d cycles, want idle", n);
    end
    @(negedge clock);
  endtask

  task automatic pulse(bit f, bit c, int row, int col);
    full_req = f; cell_req = c; cell_row = 3'(row); cell_col = 3'(col);
    @(negedge clock);
    full_req = 0; cell_req = 0;
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_addr"}, board_addr, 0);
    check({tag, "_x"}, tile_x, 0);
    check({tag, "_y"}, tile_y, 0);
    check({tag, "_sel"}, tile_select, 0);
    check({tag, "_start"}, tile_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame"}, frame_done, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got time limit reached, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus
  int f0;
  int n;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 2'b00;
    cursor_row = 3; cursor_col = 3;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    resetn = 1;
    repeat (2) @(negedge clock);
    check("post_reset_busy", busy, 0);

    // full frame on an empty board, slow plotter
    plot_lat = 150;
    start_log.delete(); f0 = n_frames;
    full_req = 1;
    @(negedge clock); full_req = 0;
    check("full_fetch_addr", board_addr, 0);
    check("full_fetch_start", tile_start, 0);
    @(negedge clock); check("full_read_start", tile_start, 0);
    @(negedge clock); check("full_first_start", tile_start, 1);
    wait_idle(20000);
    check("full_starts", start_log.size(), 64 + OVL);
    check("full_first_tile", start_log[0], {8'd16, 7'd12, 2'd0});
    check("full_last_tile", start_log[start_log.size() - 1], {8'd100, 7'd96, 2'd0});
    check("full_frames", n_frames - f0, 1);

    // single cell, white disk
    plot_lat = 5; cursor_row = 0; cursor_col = 0; mem[29] = 2'b11;
    start_log.delete(); f0 = n_frames;
    cell_req = 1; cell_row = 3; cell_col = 5;
    @(negedge clock); cell_req = 0;
    check("cell_fetch_addr", board_addr, 29);
    check("cell_fetch_busy", busy, 1);
    @(negedge clock); check("cell_read_start", tile_start, 0);
    @(negedge clock);
    check("cell_start", tile_start, 1);
    check("cell_x", tile_x, 76);
    check("cell_y", tile_y, 48);
    check("cell_sel", tile_select, 3);
    wait_idle(2000);
    check("cell_starts", start_log.size(), 1);
    check("cell_frames", n_frames - f0, 0);
    check("cell_busy_after", busy, 0);

    // code 10 draws as empty
    mem[29] = 2'b10;
    start_log.delete();
    pulse(0, 1, 3, 5);
    wait_idle(2000);
    check("cell10_tile", start_log[0], {8'd76, 7'd48, 2'd0});

    // cell on the cursor
    cursor_row = 3; cursor_col = 5; mem[29] = 2'b01;
    start_log.delete();
    pulse(0, 1, 3, 5);
    wait_idle(2000);
    check("cursor_starts", start_log.size(), 1 + OVL);
    check("cursor_tile", start_log[0], {8'd76, 7'd48, 2'd1});
`ifdef CURSOR_OVERLAY_EN
    check("cursor_overlay", start_log[1], {8'd76, 7'd48, 2'd2});
`endif

    // requests during a full redraw: cells absorbed, second frame follows
    cursor_row = 7; cursor_col = 7; plot_lat = 3;
    start_log.delete(); f0 = n_frames;
    pulse(1, 0, 0, 0);
    repeat (20) @(negedge clock);
    pulse(0, 1, 1, 1);
    repeat (10) @(negedge clock);
    pulse(0, 1, 2, 2);
    repeat (10) @(negedge clock);
    pulse(1, 0, 0, 0);
    wait_idle(30000);
    check("busyreq_starts", start_log.size(), 128 + 2 * OVL);
    check("busyreq_frames", n_frames - f0, 2);

    // simultaneous full and cell in idle
    start_log.delete(); f0 = n_frames;
    pulse(1, 1, 4, 4);
    wait_idle(30000);
    check("simul_starts", start_log.size(), 64 + OVL);
    check("simul_frames", n_frames - f0, 1);

    // spurious tile_done while idle
    start_log.delete();
    spur_done = 1; @(negedge clock); spur_done = 0;
    repeat (5) @(negedge clock);
    check("spur_busy", busy, 0);
    check("spur_starts", start_log.size(), 0);

    // reset while waiting on cell 10
    plot_lat = 40;
    start_log.delete();
    pulse(1, 0, 0, 0);
    n = 0;
    while (start_log.size() < 11 && n < 3000) begin @(negedge clock); n++; end
    check("rst_reach_cell10", start_log.size(), 11);
    repeat (5) @(negedge clock);
    #2 resetn = 0;
    #1 check_outputs_zero("midreset");
    @(negedge clock); @(negedge clock);
    resetn = 1;
    repeat (50) @(negedge clock);
    check("post_reset_starts", start_log.size(), 11);
    check("post_reset_idle", busy, 0);

    // random requests against the model
    for (int i = 0; i < 64; i++) mem[i] = 2'($urandom_range(0, 3));
    cursor_row = 3'($urandom_range(0, 7)); cursor_col = 3'($urandom_range(0, 7));
    rand_lat = 1;
    for (int i = 0; i < 4000; i++) begin
      full_req = ($urandom_range(0, 299) == 0);
      cell_req = ($urandom_range(0, 11) == 0);
      cell_row = 3'($urandom_range(0, 7));
      cell_col = 3'($urandom_range(0, 7));
      @(negedge clock);
    end
    full_req = 0; cell_req = 0;
    wait_idle(30000);
    check("random_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
